// File: rtl/pattern_peak_hold_pkg.sv
// Shared definitions for the CFEB pattern path: field widths, pattern field
// slices, the peak-hold FSM encoding and the pattern ranking helper.
package pattern_peak_hold_pkg;

  localparam int MXPATB = 7;
  localparam int MXHITB = 3;
  localparam int MXPIDB = 4;
  localparam int MXKEYB = 5;

  localparam int HIT_MSB  = 6;
  localparam int HIT_LSB  = 4;
  localparam int PID_MSB  = 3;
  localparam int PID_LSB  = 0;
  localparam int RANK_MSB = 6;
  localparam int RANK_LSB = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIFT = 2'd1,
    FIRE  = 2'd2,
    DEAD  = 2'd3
  } state_t;

  // Rank drops the ID lsb (bend direction) so both bends of a pattern tie.
  function automatic logic pat_better(input logic [MXPATB-1:0] a,
                                      input logic [MXPATB-1:0] b);
    return a[RANK_MSB:RANK_LSB] > b[RANK_MSB:RANK_LSB];
  endfunction

endpackage

// File: rtl/pattern_peak_hold.sv
// Holds the best qualifying CFEB pattern over a drift window, fires a one-cycle
// CLCT candidate strobe, then blocks new candidates for a programmable dead time.
module pattern_peak_hold
  import pattern_peak_hold_pkg::*;
#(
  parameter int MXDRIFT = 2,
  parameter int MXDEAD  = 4,
  parameter int MXCNT   = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [MXPATB-1:0]  best_pat,
  input  logic [MXKEYB-1:0]  best_key,
  input  logic [MXHITB-1:0]  hit_thresh,
  input  logic [MXPIDB-1:0]  pid_thresh,
  input  logic [MXDRIFT-1:0] drift_delay,
  input  logic [MXDEAD-1:0]  dead_time,
  input  logic               cnt_clear,
  output logic               clct_vld,
  output logic [MXPATB-1:0]  clct_pat,
  output logic [MXKEYB-1:0]  clct_key,
  output logic               busy,
  output logic [MXCNT-1:0]   fire_cnt
);

  state_t              r_state;
  logic [MXPATB-1:0]   r_hold_pat;
  logic [MXKEYB-1:0]   r_hold_key;
  logic [MXDRIFT-1:0]  r_drift_cnt;
  logic [MXDEAD-1:0]   r_dead_cnt;
  logic                r_clct_vld;
  logic [MXPATB-1:0]   r_clct_pat;
  logic [MXKEYB-1:0]   r_clct_key;
  logic                r_busy;
  logic [MXCNT-1:0]    r_fire_cnt;

  logic                w_qualify;
  logic                w_replace;
  logic [MXPATB-1:0]   w_cand_pat;
  logic [MXKEYB-1:0]   w_cand_key;

  assign w_qualify  = (best_pat[HIT_MSB:HIT_LSB] >= hit_thresh) &&
                      (best_pat[PID_MSB:PID_LSB] >= pid_thresh);
  assign w_replace  = w_qualify && pat_better(best_pat, r_hold_pat);
  // Candidate including this cycle's input, so the last drift cycle can still win.
  assign w_cand_pat = w_replace ? best_pat : r_hold_pat;
  assign w_cand_key = w_replace ? best_key : r_hold_key;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_hold_pat  <= '0;
      r_hold_key  <= '0;
      r_drift_cnt <= '0;
      r_dead_cnt  <= '0;
      r_clct_vld  <= 1'b0;
      r_clct_pat  <= '0;
      r_clct_key  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_clct_vld <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_qualify) begin
            r_hold_pat  <= best_pat;
            r_hold_key  <= best_key;
            r_drift_cnt <= drift_delay;
            r_busy      <= 1'b1;
            r_state     <= DRIFT;
          end
        end
        DRIFT: begin
          r_hold_pat <= w_cand_pat;
          r_hold_key <= w_cand_key;
          if (r_drift_cnt == '0) begin
            r_clct_vld <= 1'b1;
            r_clct_pat <= w_cand_pat;
            r_clct_key <= w_cand_key;
            r_state    <= FIRE;
          end else begin
            r_drift_cnt <= r_drift_cnt - MXDRIFT'(1);
          end
        end
        FIRE: begin
          if (dead_time == '0) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_dead_cnt <= dead_time;
            r_state    <= DEAD;
          end
        end
        DEAD: begin
          // Leaving on the count of one gives exactly dead_time DEAD cycles.
          if (r_dead_cnt <= MXDEAD'(1)) begin
            r_dead_cnt <= '0;
            r_busy     <= 1'b0;
            r_state    <= IDLE;
          end else begin
            r_dead_cnt <= r_dead_cnt - MXDEAD'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Clear has priority over the increment from a coincident FIRE cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_fire_cnt <= '0;
    end else if (cnt_clear) begin
      r_fire_cnt <= '0;
    end else if ((r_state == FIRE) && (r_fire_cnt != '1)) begin
      r_fire_cnt <= r_fire_cnt + MXCNT'(1);
    end
  end

  assign clct_vld = r_clct_vld;
  assign clct_pat = r_clct_pat;
  assign clct_key = r_clct_key;
  assign busy     = r_busy;
  assign fire_cnt = r_fire_cnt;

endmodule
